hash_job_ctrl: RTL and testbench

HASH_JOB_CTRL -- requirements
Module: hash_job_ctrl

---
 rtl/hash_job_ctrl.sv | 154 +++++++++++++++
 tb/tb_hash_job_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_job_ctrl.sv
// Job sequencer for a free-running hash core: clears the core, runs it under a
// cycle budget, watches for a hash below target and hands back one result per job.
module hash_job_ctrl #(
  parameter int CLEAR_CYCLES = 2,
  parameter int BUDGET_W     = 32
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [607:0]        job_header,
  input  logic [255:0]        job_target,
  input  logic [BUDGET_W-1:0] job_budget,
  input  logic                abort,
  output logic [607:0]        core_block,
  output logic                core_enable,
  output logic                core_rst,
  input  logic [255:0]        core_best_hash,
  input  logic [31:0]         core_best_nonce,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [255:0]        res_hash,
  output logic [31:0]         res_nonce,
  output logic [BUDGET_W-1:0] res_cycles,
  output logic                res_found,
  output logic                res_aborted,
  output logic                busy
);

  // state    | meaning
  // S_IDLE   | waiting for a job offer
  // S_CLEAR  | core held in reset before the run
  // S_RUN    | core enabled, counting cycles, watching for a hit
  // S_REPORT | result offered until accepted
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_REPORT} state_t;

  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLEAR_CYCLES - 1);

  state_t              r_state;
  state_t              w_next;
  logic [607:0]        r_header;
  logic [255:0]        r_target;
  logic [BUDGET_W-1:0] r_budget;
  logic [BUDGET_W-1:0] r_cycles;
  logic [CLR_W-1:0]    r_clr_cnt;
  logic [255:0]        r_res_hash;
  logic [31:0]         r_res_nonce;
  logic                r_found;
  logic                r_aborted;

  logic                w_hit;
  logic                w_last_clr;
  logic                w_budget_done;
  logic [BUDGET_W-1:0] w_k;

  assign w_hit         = core_best_hash < r_target;
  assign w_last_clr    = (r_clr_cnt == '0);
  // r_cycles holds k-1 during RUN cycle k; k never exceeds the budget, so no wrap
  assign w_k           = r_cycles + BUDGET_W'(1);
  assign w_budget_done = (w_k == r_budget);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    job_ready   = 1'b0;
    core_enable = 1'b0;
    core_rst    = rst_i;
    res_valid   = 1'b0;
    busy        = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        job_ready = ~rst_i;
        busy      = 1'b0;
        if (job_valid) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        core_rst = 1'b1;
        if (abort)           w_next = S_REPORT;
        else if (w_last_clr) w_next = (r_budget != '0) ? S_RUN : S_REPORT;
      end
      S_RUN: begin
        core_enable = 1'b1;
        if (w_hit || abort || w_budget_done) w_next = S_REPORT;
      end
      S_REPORT: begin
        res_valid = 1'b1;
        if (res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_header    <= '0;
      r_target    <= '0;
      r_budget    <= '0;
      r_cycles    <= '0;
      r_clr_cnt   <= '0;
      r_res_hash  <= '0;
      r_res_nonce <= '0;
      r_found     <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (job_valid) begin
            r_header  <= job_header;
            r_target  <= job_target;
            r_budget  <= job_budget;
            r_clr_cnt <= CLR_LOAD;
            r_cycles  <= '0;
          end
        end
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt - CLR_W'(1);
          // no hash has been produced yet, so the payload reads as "worst possible"
          if (abort || w_last_clr) begin
            r_found     <= 1'b0;
            r_aborted   <= abort;
            r_res_hash  <= '1;
            r_res_nonce <= '0;
            r_cycles    <= '0;
          end
        end
        S_RUN: begin
          r_cycles    <= w_k;
          r_found     <= w_hit;
          r_aborted   <= ~w_hit & abort;
          r_res_hash  <= core_best_hash;
          r_res_nonce <= core_best_nonce;
        end
        S_REPORT: ;
        default: ;
      endcase
    end
  end

  assign core_block  = r_header;
  assign res_hash    = r_res_hash;
  assign res_nonce   = r_res_nonce;
  assign res_cycles  = r_cycles;
  assign res_found   = r_found;
  assign res_aborted = r_aborted;

endmodule

// File: tb/tb_hash_job_ctrl.sv
// Randomized bench for hash_job_ctrl: per-job hash streams are scored by a
// loop-based reference model of the job rules.
module tb_hash_job_ctrl;

  localparam int CLR = 2;
  localparam int BW  = 6;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          job_valid;
  logic          job_ready;
  logic [607:0]  job_header;
  logic [255:0]  job_target;
  logic [BW-1:0] job_budget;
  logic          abort;
  logic [607:0]  core_block;
  logic          core_enable;
  logic          core_rst;
  logic [255:0]  core_best_hash;
  logic [31:0]   core_best_nonce;
  logic          res_valid;
  logic          res_ready;
  logic [255:0]  res_hash;
  logic [31:0]   res_nonce;
  logic [BW-1:0] res_cycles;
  logic          res_found;
  logic          res_aborted;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [255:0] hash_a  [0:63];
  logic [31:0]  nonce_a [0:63];

  hash_job_ctrl #(.CLEAR_CYCLES(CLR), .BUDGET_W(BW)) dut (
    .clk(clk), .rst_i(rst_i), .job_valid(job_valid), .job_ready(job_ready),
    .job_header(job_header), .job_target(job_target), .job_budget(job_budget),
    .abort(abort), .core_block(core_block), .core_enable(core_enable),
    .core_rst(core_rst), .core_best_hash(core_best_hash),
    .core_best_nonce(core_best_nonce), .res_valid(res_valid),
    .res_ready(res_ready), .res_hash(res_hash), .res_nonce(res_nonce),
    .res_cycles(res_cycles), .res_found(res_found), .res_aborted(res_aborted),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [607:0] got, input logic [607:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [607:0] rand608();
    logic [607:0] v;
    for (int i = 0; i < 19; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // hashes never below target except at RUN cycle hit_k; some equal the target exactly
  task automatic fill(input logic [255:0] t, input int hit_k);
    for (int k = 0; k < 64; k++) begin
      hash_a[k]  = ($urandom_range(0, 3) == 0) ? t : (t | rand256());
      nonce_a[k] = $urandom;
      if (k == hit_k && t != '0) hash_a[k] = (t - 256'd1) & rand256();
    end
  endtask

  task automatic run_job(input int budget, input logic [255:0] target,
                         input int abort_k, input int abort_clr, input int hold);
    logic         e_found, e_ab, chk_payload;
    int           e_cyc, e_en, e_clr;
    logic [255:0] e_hash;
    logic [31:0]  e_nonce;
    logic [607:0] hdr;
    int           n, clr_n, en_n, overlap;

    e_found = 0; e_ab = 0; e_cyc = 0; e_en = 0; e_clr = CLR;
    e_hash = '1; e_nonce = '0; chk_payload = 1;
    if (abort_clr != 0) begin
      e_clr = abort_clr;
      e_ab  = 1;
    end else if (budget == 0) begin
      chk_payload = 0;
    end else begin
      for (int k = 1; k <= budget; k++) begin
        if (hash_a[k] < target) e_found = 1;
        else if (k == abort_k)  e_ab = 1;
        if (e_found || e_ab || k == budget) begin
          e_cyc = k; e_en = k; e_hash = hash_a[k]; e_nonce = nonce_a[k];
          break;
        end
      end
    end

    n = 0;
    while (!job_ready && n < 50) begin @(negedge clk); n++; end
    chk("job_ready_idle", job_ready, 1'b1);
    hdr        = rand608();
    job_valid  = 1'b1;
    job_header = hdr;
    job_target = target;
    job_budget = BW'(budget);
    abort      = 1'($urandom_range(0, 1));
    @(negedge clk);
    job_valid  = 1'b0;
    job_header = rand608();
    job_target = rand256();
    job_budget = BW'($urandom);

    n = 0; clr_n = 0; en_n = 0; overlap = 0;
    while (!res_valid && n < 200) begin
      abort           = 1'b0;
      core_best_hash  = rand256();
      core_best_nonce = $urandom;
      if (core_enable) begin
        if (core_rst) overlap++;
        if (en_n < 63) en_n++;
        core_best_hash  = hash_a[en_n];
        core_best_nonce = nonce_a[en_n];
        abort           = (en_n == abort_k);
      end else if (core_rst) begin
        clr_n++;
        abort = (clr_n == abort_clr);
      end
      @(negedge clk);
      n++;
    end
    abort = 1'b0;
    chk("res_valid_seen", res_valid, 1'b1);
    chk("clear_cycles", 608'(clr_n), 608'(e_clr));
    chk("enable_cycles", 608'(en_n), 608'(e_en));
    chk("rst_en_overlap", 608'(overlap), 608'd0);
    chk("core_block", core_block, hdr);

    for (int h = 0; h <= hold; h++) begin
      chk("found", res_found, e_found);
      chk("aborted", res_aborted, e_ab);
      chk("cycles", res_cycles, 608'(e_cyc));
      if (chk_payload) begin
        chk("res_hash", res_hash, e_hash);
        chk("res_nonce", res_nonce, e_nonce);
      end
      chk("report_flags", {res_valid, busy, job_ready, core_enable, core_rst}, 5'b11000);
      if (h == hold) break;
      res_ready       = 1'b0;
      job_valid       = 1'($urandom_range(0, 1));
      abort           = 1'($urandom_range(0, 1));
      core_best_hash  = rand256();
      @(negedge clk);
    end
    job_valid = 1'b0;
    abort     = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("after_handshake", {res_valid, busy, job_ready}, 3'b001);
  endtask

  task automatic reset_mid_run();
    int n;
    fill('0, 0);
    job_valid  = 1'b1;
    job_header = rand608();
    job_target = '0;
    job_budget = BW'(40);
    @(negedge clk);
    job_valid = 1'b0;
    core_best_hash = '1;
    n = 0;
    while (!core_enable && n < 20) begin @(negedge clk); n++; end
    chk("reached_run", core_enable, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst_flags", {core_enable, core_rst, res_valid, busy, job_ready}, 5'b01000);
    chk("async_rst_block", core_block, 608'd0);
    chk("async_rst_cycles", res_cycles, 608'd0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk("post_rst_flags", {job_ready, busy, res_valid, core_enable, core_rst}, 5'b10000);
  endtask

  initial begin
    int b, hk, ak, ac;
    logic [255:0] t;
    rst_i = 1'b1; job_valid = 1'b0; job_header = '0; job_target = '0;
    job_budget = '0; abort = 1'b0; res_ready = 1'b0;
    core_best_hash = '1; core_best_nonce = '0;
    repeat (3) @(negedge clk);
    chk("reset_flags", {job_ready, busy, res_valid, core_enable, core_rst}, 5'b00001);
    chk("reset_payload", {res_hash, res_nonce, res_cycles, res_found, res_aborted}, 608'd0);
    chk("reset_block", core_block, 608'd0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("release_ready", job_ready, 1'b1);

    fill('0, 0);               run_job(10, '0, 0, 0, 0);
    fill(256'h100, 0);
    for (int k = 1; k < 5; k++) hash_a[k] = 256'h100;
    hash_a[5] = 256'h1; nonce_a[5] = 32'h1234;
                               run_job(20, 256'h100, 0, 0, 0);
    fill(256'h100, 0);         run_job(10, 256'h100, 3, 0, 0);
    fill(256'h100, 4);         run_job(10, 256'h100, 4, 0, 1);
    fill(256'h100, 0);         run_job(0, 256'h100, 0, 0, 2);
    fill(256'h100, 1);         run_job(5, 256'h100, 0, 1, 0);
    fill(256'h100, 1);         run_job(5, 256'h100, 0, 2, 0);
    fill(256'h100, 0);         run_job(3, 256'h100, 0, 0, 20);
    fill('0, 0);               run_job(63, '0, 0, 0, 0);

    for (int j = 0; j < 30; j++) begin
      b  = ($urandom_range(0, 7) == 0) ? 63 : $urandom_range(0, 20);
      t  = ($urandom_range(0, 3) == 0) ? 256'($urandom) : rand256();
      hk = ($urandom_range(0, 1) == 0 || b == 0) ? 0 : $urandom_range(1, b);
      ak = ($urandom_range(0, 2) == 0 && b != 0) ? $urandom_range(1, b) : 0;
      ac = ($urandom_range(0, 5) == 0) ? $urandom_range(1, CLR) : 0;
      fill(t, hk);
      run_job(b, t, ak, ac, $urandom_range(0, 4));
    end

    reset_mid_run();
    fill(256'h100, 2);         run_job(6, 256'h100, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
